key_event_arbiter: RTL and testbench

- Shared debounce-and-event controller for up to N_KEYS push buttons.
- One prescaler tick is shared by all keys; each key has a small stable-count integrator.
- Press/release/repeat events from all keys are arbitrated into a single valid/ready event stream for the top-level FSM.
- Replaces per-key 32-bit debounce counters running on every clock.

---
 rtl/key_event_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_key_event_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_arbiter.sv
// key_event_arbiter: shared-tick debouncer for N_KEYS buttons feeding one valid/ready event stream.
// Auto-repeat events are built only when AUTO_REPEAT_EN is defined.
module key_event_arbiter #(
    parameter int N_KEYS       = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 20,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    localparam int CW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] keys_in,
    output logic [N_KEYS-1:0] key_level,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [CW-1:0]     ev_code,
    output logic [1:0]        ev_type,
    output logic              ev_ovf
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] CNT_LAST = SW'(STABLE_TICKS - 1);

    localparam logic [1:0] EV_PRESS = 2'b01;
    localparam logic [1:0] EV_REL   = 2'b10;

    logic [N_KEYS-1:0] sync1_q, sync1_d;
    logic [N_KEYS-1:0] sync2_q, sync2_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic              tick;

    logic [N_KEYS-1:0] level_q, level_d;
    logic [SW-1:0]     cnt_q [N_KEYS];
    logic [SW-1:0]     cnt_d [N_KEYS];

    logic [N_KEYS-1:0] press_pend_q, press_pend_d;
    logic [N_KEYS-1:0] rel_pend_q, rel_pend_d;
    logic [N_KEYS-1:0] press_set, rel_set;
    logic [N_KEYS-1:0] press_clr, rel_clr;
    logic [N_KEYS-1:0] drop;

    logic              valid_q, valid_d;
    logic [CW-1:0]     code_q, code_d;
    logic [1:0]        type_q, type_d;
    logic              ovf_q, ovf_d;

    logic              load;
    logic              found;
    logic [CW-1:0]     sel_code;
    logic [1:0]        sel_type;

`ifdef AUTO_REPEAT_EN
    localparam logic [1:0] EV_REP = 2'b11;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

    logic [RW-1:0]     rcnt_q [N_KEYS];
    logic [RW-1:0]     rcnt_d [N_KEYS];
    logic [N_KEYS-1:0] rfirst_q, rfirst_d;
    logic [N_KEYS-1:0] rep_pend_q, rep_pend_d;
    logic [N_KEYS-1:0] rep_set, rep_clr;
`endif

    assign tick = (pre_q == PRE_LAST);

    always_comb begin
        sync1_d = keys_in;
        sync2_d = sync1_q;
        pre_d   = tick ? '0 : pre_q + 1'b1;
    end

    // Integrator: a new level is accepted after STABLE_TICKS differing ticks.
    always_comb begin
        level_d   = level_q;
        press_set = '0;
        rel_set   = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (tick) begin
                if (sync2_q[k] != level_q[k]) begin
                    if (cnt_q[k] == CNT_LAST) begin
                        level_d[k]   = sync2_q[k];
                        cnt_d[k]     = '0;
                        press_set[k] = sync2_q[k];
                        rel_set[k]   = !sync2_q[k];
                    end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end else begin
                    cnt_d[k] = '0;
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    // rfirst marks that the initial delay has elapsed and the rate applies.
    always_comb begin
        rep_set  = '0;
        rfirst_d = rfirst_q;
        for (int k = 0; k < N_KEYS; k++) begin
            rcnt_d[k] = rcnt_q[k];
            if (tick) begin
                if (level_d[k] != level_q[k]) begin
                    rcnt_d[k]   = '0;
                    rfirst_d[k] = 1'b0;
                end else if (level_q[k]) begin
                    if (!rfirst_q[k] && rcnt_q[k] == DLY_LAST) begin
                        rep_set[k]  = 1'b1;
                        rcnt_d[k]   = '0;
                        rfirst_d[k] = 1'b1;
                    end else if (rfirst_q[k] && rcnt_q[k] == RATE_LAST) begin
                        rep_set[k] = 1'b1;
                        rcnt_d[k]  = '0;
                    end else begin
                        rcnt_d[k] = rcnt_q[k] + 1'b1;
                    end
                end
            end
        end
    end
`endif

    always_comb begin
        load      = !valid_q || ev_ready;
        found     = 1'b0;
        sel_code  = '0;
        sel_type  = EV_PRESS;
        press_clr = '0;
        rel_clr   = '0;
`ifdef AUTO_REPEAT_EN
        rep_clr   = '0;
`endif
        for (int k = 0; k < N_KEYS; k++) begin
            if (!found && press_pend_q[k]) begin
                found        = 1'b1;
                sel_code     = CW'(k);
                sel_type     = EV_PRESS;
                press_clr[k] = 1'b1;
            end
        end
`ifdef AUTO_REPEAT_EN
        for (int k = 0; k < N_KEYS; k++) begin
            if (!found && rep_pend_q[k]) begin
                found      = 1'b1;
                sel_code   = CW'(k);
                sel_type   = EV_REP;
                rep_clr[k] = 1'b1;
            end
        end
`endif
        for (int k = 0; k < N_KEYS; k++) begin
            if (!found && rel_pend_q[k]) begin
                found      = 1'b1;
                sel_code   = CW'(k);
                sel_type   = EV_REL;
                rel_clr[k] = 1'b1;
            end
        end
        if (!load) begin
            press_clr = '0;
            rel_clr   = '0;
`ifdef AUTO_REPEAT_EN
            rep_clr   = '0;
`endif
        end

        valid_d = valid_q;
        code_d  = code_q;
        type_d  = type_q;
        if (load) begin
            valid_d = found;
            if (found) begin
                code_d = sel_code;
                type_d = sel_type;
            end
        end
    end

    // A set landing on a bit that is not being drained this cycle loses the event.
    always_comb begin
        press_pend_d = (press_pend_q & ~press_clr) | press_set;
        rel_pend_d   = (rel_pend_q & ~rel_clr) | rel_set;
        drop         = (press_set & press_pend_q & ~press_clr)
                     | (rel_set & rel_pend_q & ~rel_clr);
`ifdef AUTO_REPEAT_EN
        rep_pend_d   = (rep_pend_q & ~rep_clr) | rep_set;
        drop         = drop | (rep_set & rep_pend_q & ~rep_clr);
`endif
        ovf_d        = ovf_q | (|drop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            pre_q        <= '0;
            level_q      <= '0;
            press_pend_q <= '0;
            rel_pend_q   <= '0;
            valid_q      <= 1'b0;
            code_q       <= '0;
            type_q       <= '0;
            ovf_q        <= 1'b0;
            for (int k = 0; k < N_KEYS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            pre_q        <= pre_d;
            level_q      <= level_d;
            press_pend_q <= press_pend_d;
            rel_pend_q   <= rel_pend_d;
            valid_q      <= valid_d;
            code_q       <= code_d;
            type_q       <= type_d;
            ovf_q        <= ovf_d;
            cnt_q        <= cnt_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rfirst_q   <= '0;
            rep_pend_q <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                rcnt_q[k] <= '0;
            end
        end else begin
            rfirst_q   <= rfirst_d;
            rep_pend_q <= rep_pend_d;
            rcnt_q     <= rcnt_d;
        end
    end
`endif

    assign key_level = level_q;
    assign ev_valid  = valid_q;
    assign ev_code   = code_q;
    assign ev_type   = type_q;
    assign ev_ovf    = ovf_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter: tick-level behavioural model checked every cycle,
// plus directed scenarios with literal expected event logs.
module tb_key_event_arbiter;
    localparam int N  = 4;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int RD = 5;
    localparam int RR = 2;
    localparam int CW = 2;

`ifdef AUTO_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic [N-1:0]  keys_in  = '1;
    logic          ev_ready = 1'b1;
    logic [N-1:0]  key_level;
    logic          ev_valid;
    logic [CW-1:0] ev_code;
    logic [1:0]    ev_type;
    logic          ev_ovf;

    key_event_arbiter #(
        .N_KEYS      (N),
        .TICK_DIV    (TD),
        .STABLE_TICKS(ST),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .keys_in  (keys_in),
        .key_level(key_level),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_code  (ev_code),
        .ev_type  (ev_type),
        .ev_ovf   (ev_ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] ev_log [$];
    logic [3:0] exp_q  [$];
    bit         log_rep    = 1'b0;
    bit         seen_valid = 1'b0;

    // Model state: levels, pending flags, ticks held since press, recent samples.
    bit         m_lvl   [N];
    bit         m_press [N];
    bit         m_rel   [N];
    bit         m_rep   [N];
    int         m_held  [N];
    bit [ST-1:0] m_hist [N];
    int         m_hcnt  [N];
    bit         m_valid, m_ovf, m_rst;
    int         m_code, m_type, m_n;
    bit [N-1:0] m_s1, m_s2;

    task automatic chk(string nm, logic [31:0] act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic post(int kind, int k);
        case (kind)
            1: if (m_press[k]) m_ovf = 1'b1; else m_press[k] = 1'b1;
            2: if (m_rel[k])   m_ovf = 1'b1; else m_rel[k]   = 1'b1;
            default: if (m_rep[k]) m_ovf = 1'b1; else m_rep[k] = 1'b1;
        endcase
    endtask

    task automatic model_step();
        bit         tick;
        bit         found;
        bit [N-1:0] smp;
        bit [ST-1:0] want;
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                m_lvl[k] = 0; m_press[k] = 0; m_rel[k] = 0; m_rep[k] = 0;
                m_held[k] = 0; m_hist[k] = '0; m_hcnt[k] = 0;
            end
            m_valid = 0; m_ovf = 0; m_code = 0; m_type = 0;
            m_n = 0; m_s1 = '0; m_s2 = '0; m_rst = 1;
            return;
        end
        m_rst = 0;
        tick  = (m_n % TD) == TD - 1;
        m_n++;
        smp  = m_s2;
        m_s2 = m_s1;
        m_s1 = keys_in;
        if (!m_valid || ev_ready) begin
            found = 0;
            for (int k = 0; k < N; k++)
                if (!found && m_press[k]) begin
                    found = 1; m_code = k; m_type = 1; m_press[k] = 0;
                end
            for (int k = 0; k < N; k++)
                if (!found && m_rep[k]) begin
                    found = 1; m_code = k; m_type = 3; m_rep[k] = 0;
                end
            for (int k = 0; k < N; k++)
                if (!found && m_rel[k]) begin
                    found = 1; m_code = k; m_type = 2; m_rel[k] = 0;
                end
            m_valid = found;
        end
        if (tick) begin
            for (int k = 0; k < N; k++) begin
                m_hist[k] = {m_hist[k][ST-2:0], smp[k]};
                m_hcnt[k]++;
                want = m_lvl[k] ? '0 : '1;
                if (m_hcnt[k] >= ST && m_hist[k] == want) begin
                    m_lvl[k]  = !m_lvl[k];
                    m_hcnt[k] = 0;
                    m_held[k] = 0;
                    post(m_lvl[k] ? 1 : 2, k);
                end else if (m_lvl[k]) begin
                    m_held[k]++;
                    if (REP_ON && (m_held[k] == RD ||
                        (m_held[k] > RD && (m_held[k] - RD) % RR == 0)))
                        post(3, k);
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        bit [N-1:0] e_lvl;
        @(negedge clk);
        for (int k = 0; k < N; k++) e_lvl[k] = m_lvl[k];
        chk("cyc_level", 32'(key_level), int'(e_lvl));
        chk("cyc_valid", 32'(ev_valid), int'(m_valid));
        chk("cyc_ovf", 32'(ev_ovf), int'(m_ovf));
        if (m_valid || m_rst) begin
            chk("cyc_code", 32'(ev_code), m_code);
            chk("cyc_type", 32'(ev_type), m_type);
        end
        if (rst_n && ev_valid) seen_valid = 1'b1;
        if (rst_n && ev_valid && ev_ready && (log_rep || ev_type != 2'b11))
            ev_log.push_back({ev_code, ev_type});
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_log(string nm);
        chk({nm, "_count"}, 32'(ev_log.size()), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ev_log.size(); i++)
            chk($sformatf("%s_ev%0d", nm, i), 32'(ev_log[i]), int'(exp_q[i]));
        ev_log.delete();
    endtask

    task automatic do_reset();
        keys_in = '0;
        rst_n   = 1'b0;
        cyc(3);
        ev_log.delete();
        seen_valid = 1'b0;
        rst_n = 1'b1;
        cyc(2);
    endtask

    initial begin
        int w;
        // Reset held with every key down
        cyc(3);
        @(negedge clk);
        chk("rst_level", 32'(key_level), 0);
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_code", 32'(ev_code), 0);
        chk("rst_type", 32'(ev_type), 0);
        chk("rst_ovf", 32'(ev_ovf), 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(30);
        chk("s1_level", 32'(key_level), 15);
        exp_q = '{4'b0001, 4'b0101, 4'b1001, 4'b1101};
        check_log("s1");

        // Two-tick glitch on key 2
        do_reset();
        keys_in = 4'b0100;
        cyc(8);
        keys_in = 4'b0000;
        cyc(30);
        chk("s2_level", 32'(key_level), 0);
        chk("s2_seen_valid", 32'(seen_valid), 0);
        exp_q = '{};
        check_log("s2");

        // Held event under back-pressure, then release drains back-to-back
        do_reset();
        ev_ready = 1'b0;
        keys_in  = 4'b0010;
        cyc(30);
        chk("s3_valid", 32'(ev_valid), 1);
        chk("s3_code", 32'(ev_code), 1);
        chk("s3_type", 32'(ev_type), 1);
        cyc(10);
        chk("s3_valid_hold", 32'(ev_valid), 1);
        chk("s3_code_hold", 32'(ev_code), 1);
        chk("s3_type_hold", 32'(ev_type), 1);
        keys_in = 4'b0000;
        cyc(30);
        ev_ready = 1'b1;
        cyc(6);
        exp_q = '{4'b0101, 4'b0110};
        check_log("s3");

        // Press/release twice while stalled: second release is dropped
        do_reset();
        ev_ready = 1'b0;
        keys_in = 4'b0001; cyc(14);
        keys_in = 4'b0000; cyc(20);
        keys_in = 4'b0001; cyc(14);
        keys_in = 4'b0000; cyc(30);
        chk("s4_ovf", 32'(ev_ovf), 1);
        chk("s4_valid", 32'(ev_valid), 1);
        chk("s4_code", 32'(ev_code), 0);
        chk("s4_type", 32'(ev_type), 1);
        ev_ready = 1'b1;
        cyc(6);
        exp_q = '{4'b0001, 4'b0001, 4'b0010};
        check_log("s4");
        cyc(10);
        chk("s4_ovf_sticky", 32'(ev_ovf), 1);
        do_reset();
        chk("s4_ovf_reset", 32'(ev_ovf), 0);

        // Keys 3 and 0 in the same tick
        keys_in = 4'b1001;
        cyc(30);
        exp_q = '{4'b0001, 4'b1101};
        check_log("s5");

        // Reset while an event is held and others pending
        ev_ready = 1'b0;
        keys_in  = 4'b1111;
        cyc(30);
        chk("s6_valid_pre", 32'(ev_valid), 1);
        do_reset();
        ev_ready = 1'b1;
        cyc(30);
        chk("s6_seen_valid", 32'(seen_valid), 0);
        exp_q = '{};
        check_log("s6");

`ifdef AUTO_REPEAT_EN
        // Key 2 level held 12 ticks: repeats at +5, +7, +9, +11
        do_reset();
        log_rep = 1'b1;
        keys_in = 4'b0100;
        w = 0;
        while (!key_level[2] && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("s7_press_wait", 32'(key_level[2]), 1);
        repeat (36) @(posedge clk);
        #2;
        keys_in = 4'b0000;
        cyc(60);
        exp_q = '{4'b1001, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1010};
        check_log("s7");
        log_rep = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
